// File: rtl/mem_bank.sv
// mem_bank: DEPTH independently addressed WIDTH-bit entries, each with its own
// valid flag. It sits between the tester stimulus/result logic and the readout
// path, and is the parametrised successor to the single capture register.
//
// Ports:
//   in_clk          clock, all state updates on the rising edge
//   in_rst          asynchronous active-high reset (clears data, flags, outputs)
//   in_wr_en        write request
//   in_wr_addr      write address (AW bits; addresses >= DEPTH are ignored)
//   in_wr_data      write data
//   in_rd_en        read request
//   in_rd_addr      read address (AW bits; addresses >= DEPTH read as a miss)
//   in_clr          synchronous clear of all valid flags, count and write ack
//   out_rd_data     registered read data, zero on a miss
//   out_rd_valid    one-cycle pulse, one cycle after in_rd_en
//   out_rd_hit      read entry was valid, qualified by out_rd_valid
//   out_wr_done     write acknowledge: sticky (WR_ACK_MODE=0) or pulse (=1)
//   out_valid_mask  per-entry valid flags, bit i = entry i
//   out_count       number of valid entries, always popcount(out_valid_mask)
module mem_bank #(
  parameter int WIDTH       = 6,
  parameter int DEPTH       = 4,
  parameter int AW          = $clog2(DEPTH),
  parameter int WR_ACK_MODE = 0,
  parameter int RD_BYPASS   = 1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_wr_en,
  input  logic [AW-1:0]    in_wr_addr,
  input  logic [WIDTH-1:0] in_wr_data,
  input  logic             in_rd_en,
  input  logic [AW-1:0]    in_rd_addr,
  input  logic             in_clr,
  output logic [WIDTH-1:0] out_rd_data,
  output logic             out_rd_valid,
  output logic             out_rd_hit,
  output logic             out_wr_done,
  output logic [DEPTH-1:0] out_valid_mask,
  output logic [AW:0]      out_count
);

  // One extra bit so the range check also works when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_p1;
  logic [AW:0]      count_p1;
  logic             wr_done_p1;
  logic             vld_p1;
  logic             rd_hit_p1;
  logic [WIDTH-1:0] rd_data_p1;

  logic             wr_in_range_p0;
  logic             rd_in_range_p0;
  logic             wr_ok_p0;
  logic             wr_new_p0;
  logic             bypass_p0;
  logic             rd_entry_valid_p0;
  logic             rd_hit_p0;
  logic [AW-1:0]    wr_idx_p0;
  logic [AW-1:0]    rd_idx_p0;
  logic [WIDTH-1:0] rd_data_p0;

  // ---- Stage p0: address qualification, write acceptance, read lookup ----
  always_comb begin
    wr_in_range_p0    = ({1'b0, in_wr_addr} < DEPTH_V);
    rd_in_range_p0    = ({1'b0, in_rd_addr} < DEPTH_V);
    // Out-of-range addresses are steered to entry 0 so no array access ever
    // goes past the end; their results are masked by the range flags.
    wr_idx_p0         = wr_in_range_p0 ? in_wr_addr : '0;
    rd_idx_p0         = rd_in_range_p0 ? in_rd_addr : '0;
    // Clear wins over a simultaneous write.
    wr_ok_p0          = in_wr_en & ~in_clr & wr_in_range_p0;
    wr_new_p0         = wr_ok_p0 & ~valid_p1[wr_idx_p0];
    // Since wr_ok_p0 is already low during a clear, no bypass applies then.
    bypass_p0         = (RD_BYPASS != 0) && wr_ok_p0 && (in_wr_addr == in_rd_addr);
    rd_entry_valid_p0 = rd_in_range_p0 & valid_p1[rd_idx_p0];
    rd_hit_p0         = bypass_p0 | rd_entry_valid_p0;
    rd_data_p0        = '0;
    if (bypass_p0) begin
      rd_data_p0 = in_wr_data;
    end else if (rd_entry_valid_p0) begin
      rd_data_p0 = mem[rd_idx_p0];
    end
  end

  // ---- Stage p1: storage, flags, count, acknowledge and read result ----
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid_p1   <= '0;
      count_p1   <= '0;
      wr_done_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      rd_hit_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      // Storage is left untouched by a clear; only the flags drop.
      if (wr_ok_p0) begin
        mem[wr_idx_p0] <= in_wr_data;
      end

      if (in_clr) begin
        valid_p1 <= '0;
        count_p1 <= '0;
      end else begin
        if (wr_ok_p0) begin
          valid_p1[wr_idx_p0] <= 1'b1;
        end
        // Only a write to a previously empty entry grows the count, so the
        // count stays equal to the popcount of the mask.
        if (wr_new_p0) begin
          count_p1 <= count_p1 + {{AW{1'b0}}, 1'b1};
        end
      end

      if (WR_ACK_MODE == 1) begin
        wr_done_p1 <= wr_ok_p0;
      end else if (in_clr) begin
        wr_done_p1 <= 1'b0;
      end else if (wr_ok_p0) begin
        wr_done_p1 <= 1'b1;
      end

      vld_p1 <= in_rd_en;
      if (in_rd_en) begin
        rd_data_p1 <= rd_data_p0;
        rd_hit_p1  <= rd_hit_p0;
      end
    end
  end

  assign out_rd_data    = rd_data_p1;
  assign out_rd_valid   = vld_p1;
  assign out_rd_hit     = rd_hit_p1;
  assign out_wr_done    = wr_done_p1;
  assign out_valid_mask = valid_p1;
  assign out_count      = count_p1;

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank. Three instances share one stimulus bus:
//   a: defaults (DEPTH=4, sticky ack, read bypass on)
//   b: DEPTH=4, pulsed ack, read bypass off
//   c: DEPTH=3, sticky ack, read bypass on (range behaviour)
module tb_mem_bank;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic       clr;

  logic [5:0] a_rd_data, b_rd_data, c_rd_data;
  logic       a_rd_valid, b_rd_valid, c_rd_valid;
  logic       a_rd_hit, b_rd_hit, c_rd_hit;
  logic       a_wr_done, b_wr_done, c_wr_done;
  logic [3:0] a_mask, b_mask;
  logic [2:0] c_mask;
  logic [2:0] a_count, b_count, c_count;

  int checks;
  int errors;

  mem_bank #(.WIDTH(6), .DEPTH(4), .WR_ACK_MODE(0), .RD_BYPASS(1)) dut_a (
    .in_clk(clk), .in_rst(rst), .in_wr_en(wr_en), .in_wr_addr(wr_addr),
    .in_wr_data(wr_data), .in_rd_en(rd_en), .in_rd_addr(rd_addr), .in_clr(clr),
    .out_rd_data(a_rd_data), .out_rd_valid(a_rd_valid), .out_rd_hit(a_rd_hit),
    .out_wr_done(a_wr_done), .out_valid_mask(a_mask), .out_count(a_count)
  );

  mem_bank #(.WIDTH(6), .DEPTH(4), .WR_ACK_MODE(1), .RD_BYPASS(0)) dut_b (
    .in_clk(clk), .in_rst(rst), .in_wr_en(wr_en), .in_wr_addr(wr_addr),
    .in_wr_data(wr_data), .in_rd_en(rd_en), .in_rd_addr(rd_addr), .in_clr(clr),
    .out_rd_data(b_rd_data), .out_rd_valid(b_rd_valid), .out_rd_hit(b_rd_hit),
    .out_wr_done(b_wr_done), .out_valid_mask(b_mask), .out_count(b_count)
  );

  mem_bank #(.WIDTH(6), .DEPTH(3), .WR_ACK_MODE(0), .RD_BYPASS(1)) dut_c (
    .in_clk(clk), .in_rst(rst), .in_wr_en(wr_en), .in_wr_addr(wr_addr),
    .in_wr_data(wr_data), .in_rd_en(rd_en), .in_rd_addr(rd_addr), .in_clr(clr),
    .out_rd_data(c_rd_data), .out_rd_valid(c_rd_valid), .out_rd_hit(c_rd_hit),
    .out_wr_done(c_wr_done), .out_valid_mask(c_mask), .out_count(c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later; inputs are driven right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [5:0] wd,
                       input logic re, input logic [1:0] ra, input logic c);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = c;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [5:0] fill_data [4];

  initial begin
    checks = 0;
    errors = 0;
    fill_data[0] = 6'h15; fill_data[1] = 6'h2A;
    fill_data[2] = 6'h3F; fill_data[3] = 6'h01;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    do_reset();

    chk("rst_a_count", a_count, 0);
    chk("rst_a_mask", a_mask, 0);
    chk("rst_a_valid", a_rd_valid, 0);
    chk("rst_a_done", a_wr_done, 0);
    chk("rst_c_count", c_count, 0);

    // Fill addresses 0..3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), fill_data[i], 1'b0, 2'd0, 1'b0);
      step();
      chk("fill_a_count", a_count, i + 1);
      chk("fill_a_done", a_wr_done, 1);
      chk("fill_b_done", b_wr_done, 1);
    end
    chk("fill_a_mask", a_mask, 4'hF);
    chk("fill_c_count", c_count, 3);
    chk("fill_c_mask", c_mask, 3'h7);

    // Back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 6'd0, 1'b1, 2'(i), 1'b0);
      step();
      chk("rd_a_valid", a_rd_valid, 1);
      chk("rd_a_hit", a_rd_hit, 1);
      chk("rd_a_data", a_rd_data, fill_data[i]);
    end
    chk("rd_c_range_valid", c_rd_valid, 1);
    chk("rd_c_range_hit", c_rd_hit, 0);
    chk("rd_c_range_data", c_rd_data, 0);
    idle();
    step();
    chk("hold_a_valid", a_rd_valid, 0);
    chk("hold_a_data", a_rd_data, 6'h01);
    chk("hold_a_hit", a_rd_hit, 1);
    chk("hold_b_done", b_wr_done, 0);
    chk("hold_a_done", a_wr_done, 1);

    // Overwrite and ack modes
    do_reset();
    drive(1'b1, 2'd2, 6'h3F, 1'b0, 2'd0, 1'b0);
    step();
    chk("ow1_a_count", a_count, 1);
    chk("ow1_b_done", b_wr_done, 1);
    idle();
    step();
    chk("ow_gap_b_done", b_wr_done, 0);
    chk("ow_gap_a_done", a_wr_done, 1);
    drive(1'b1, 2'd2, 6'h07, 1'b0, 2'd0, 1'b0);
    step();
    chk("ow2_a_count", a_count, 1);
    chk("ow2_b_count", b_count, 1);
    chk("ow2_b_done", b_wr_done, 1);
    drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 1'b0);
    step();
    chk("ow_rd_a_data", a_rd_data, 6'h07);
    chk("ow_rd_b_data", b_rd_data, 6'h07);
    chk("ow_rd_b_done", b_wr_done, 0);

    // Same-cycle write and read on address 1
    drive(1'b1, 2'd1, 6'h11, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'd1, 6'h22, 1'b1, 2'd1, 1'b0);
    step();
    chk("byp_a_data", a_rd_data, 6'h22);
    chk("byp_a_hit", a_rd_hit, 1);
    chk("nobyp_b_data", b_rd_data, 6'h11);
    chk("nobyp_b_hit", b_rd_hit, 1);
    drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0);
    step();
    chk("after_b_data", b_rd_data, 6'h22);
    // Same-cycle on a previously invalid entry
    drive(1'b1, 2'd3, 6'h33, 1'b1, 2'd3, 1'b0);
    step();
    chk("byp_new_a_data", a_rd_data, 6'h33);
    chk("byp_new_a_hit", a_rd_hit, 1);
    chk("nobyp_new_b_data", b_rd_data, 0);
    chk("nobyp_new_b_hit", b_rd_hit, 0);
    chk("byp_oor_c_hit", c_rd_hit, 0);
    chk("byp_oor_c_data", c_rd_data, 0);
    drive(1'b1, 2'd0, 6'h2A, 1'b0, 2'd0, 1'b0);
    step();
    chk("pre_clr_a_count", a_count, 4);
    chk("pre_clr_c_count", c_count, 3);

    // Clear with a simultaneous write to 0 and read of 3
    drive(1'b1, 2'd0, 6'h05, 1'b1, 2'd3, 1'b1);
    step();
    chk("clr_a_rd_data", a_rd_data, 6'h33);
    chk("clr_a_rd_hit", a_rd_hit, 1);
    chk("clr_b_rd_data", b_rd_data, 6'h33);
    chk("clr_a_count", a_count, 0);
    chk("clr_a_mask", a_mask, 0);
    chk("clr_a_done", a_wr_done, 0);
    chk("clr_b_done", b_wr_done, 0);
    chk("clr_c_count", c_count, 0);
    drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd0, 1'b0);
    step();
    chk("clr_rd0_valid", a_rd_valid, 1);
    chk("clr_rd0_hit", a_rd_hit, 0);
    chk("clr_rd0_data", a_rd_data, 0);

    // Out-of-range write on the DEPTH=3 instance
    drive(1'b1, 2'd3, 6'h3C, 1'b0, 2'd0, 1'b0);
    step();
    chk("oor_c_count", c_count, 0);
    chk("oor_c_mask", c_mask, 0);
    chk("oor_c_done", c_wr_done, 0);
    chk("oor_a_count", a_count, 1);
    drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd3, 1'b0);
    step();
    chk("oor_rd_c_valid", c_rd_valid, 1);
    chk("oor_rd_c_hit", c_rd_hit, 0);
    chk("oor_rd_c_data", c_rd_data, 0);
    chk("oor_rd_a_data", a_rd_data, 6'h3C);

    // Asynchronous reset in the middle of a read stream
    step();
    chk("pre_rst_a_valid", a_rd_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_a_valid", a_rd_valid, 0);
    chk("arst_a_data", a_rd_data, 0);
    chk("arst_a_hit", a_rd_hit, 0);
    chk("arst_a_count", a_count, 0);
    chk("arst_a_mask", a_mask, 0);
    chk("arst_a_done", a_wr_done, 0);
    idle();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_a_valid", a_rd_valid, 0);
    chk("post_rst_a_count", a_count, 0);
    drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd3, 1'b0);
    step();
    chk("post_rst_rd_hit", a_rd_hit, 0);
    chk("post_rst_rd_data", a_rd_data, 0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
